// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the core's
// memory stage. A word-organised RAM answers one load/store at a time after a
// fixed number of wait cycles, with right-justified read data and a bus-error
// flag for out-of-range or misaligned accesses.
//
// Ports:
//   clk, reset           clock (rising edge), async active-low reset
//   req_valid_i/ready_o  request handshake (ready only while idle)
//   req_we_i             1 = store, 0 = load
//   req_size_i           0 byte, 1 half, 2 word, 3 illegal
//   req_addr_i           byte address
//   req_wdata_i          store data, right-justified
//   rsp_valid_o/ready_i  response handshake
//   rsp_rdata_o          load data, right-justified, zero-extended
//   rsp_err_o            bus error for this response
module dmem_responder #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int              LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);
  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int NB   = XLEN / 8;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [1:0]      r_size;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            w_idle;
  logic            w_accept;
  logic            w_commit;
  logic            w_we;
  logic [1:0]      w_size;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_off;
  logic [IDXW-1:0] w_idx;
  logic            w_err;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_wsh;
  logic [XLEN-1:0] w_rsh;
  logic [XLEN-1:0] w_rdat;

  assign w_idle      = (r_state == S_IDLE);
  assign w_accept    = req_valid_i & w_idle;
  assign req_ready_o = w_idle;
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

  // With zero wait cycles the commit happens on the accept edge itself, so the
  // request is taken straight from the inputs; otherwise from the captured copy.
  assign w_commit = (w_accept && (LATENCY == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == LAT4));
  assign w_we    = w_idle ? req_we_i    : r_we;
  assign w_size  = w_idle ? req_size_i  : r_size;
  assign w_addr  = w_idle ? req_addr_i  : r_addr;
  assign w_wdata = w_idle ? req_wdata_i : r_wdata;

  // XLEN-bit offset; underflow is caught by the addr < BASE compare, and any
  // set bit above the word index means the access is past the top of RAM.
  assign w_off = w_addr - BASE_ADDR;
  assign w_idx = w_off[IDXW+1:2];

  always_comb begin
    w_err = 1'b0;
    if (w_addr < BASE_ADDR)                     w_err = 1'b1;
    if (w_off[XLEN-1:IDXW+2] != '0)             w_err = 1'b1;
    if (w_size == 2'd3)                         w_err = 1'b1;
    if ((w_size == 2'd1) && w_addr[0])          w_err = 1'b1;
    if ((w_size == 2'd2) && (w_addr[1:0] != 0)) w_err = 1'b1;
  end

  always_comb begin
    case (w_size)
      2'd0:    w_be = {{(NB-1){1'b0}}, 1'b1} << w_off[1:0];
      2'd1:    w_be = {{(NB-2){1'b0}}, 2'b11} << {w_off[1], 1'b0};
      default: w_be = '1;
    endcase
  end

  assign w_wsh = w_wdata << {w_off[1:0], 3'b000};
  assign w_rsh = mem[w_idx] >> {w_off[1:0], 3'b000};

  always_comb begin
    case (w_size)
      2'd0:    w_rdat = XLEN'(w_rsh[7:0]);
      2'd1:    w_rdat = XLEN'(w_rsh[15:0]);
      default: w_rdat = w_rsh;
    endcase
  end

  // RAM is not reset; writes land only on the commit edge of a clean store.
  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_we    <= req_we_i;
          r_size  <= req_size_i;
          r_addr  <= req_addr_i;
          r_wdata <= req_wdata_i;
          if (LATENCY == 0) begin
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= 4'd1;
          end
        end
        S_WAIT: if (r_cnt == LAT4) r_state <= S_RESP;
                else               r_cnt   <= r_cnt + 4'd1;
        S_RESP: if (rsp_ready_i)   r_state <= S_IDLE;
        default:                   r_state <= S_IDLE;
      endcase
      // Response payload is latched on the edge entering RESP and then held.
      if (w_commit) begin
        r_rdata <= (!w_we && !w_err) ? w_rdat : '0;
        r_err   <= w_err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: LATENCY=1 instance, index 1: LATENCY=3 instance.
  logic        rst  [2];
  logic        vld  [2];
  logic        we   [2];
  logic [1:0]  sz   [2];
  logic [31:0] ad   [2];
  logic [31:0] wd   [2];
  logic        rrdy [2];
  logic        rdy  [2];
  logic        rv   [2];
  logic [31:0] rd   [2];
  logic        er   [2];

  int n_chk  = 0;
  int n_fail = 0;

  dmem_responder #(.LATENCY(1)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
    .req_we_i(we[0]), .req_size_i(sz[0]), .req_addr_i(ad[0]),
    .req_wdata_i(wd[0]), .rsp_valid_o(rv[0]), .rsp_ready_i(rrdy[0]),
    .rsp_rdata_o(rd[0]), .rsp_err_o(er[0]));

  dmem_responder #(.LATENCY(3)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
    .req_we_i(we[1]), .req_size_i(sz[1]), .req_addr_i(ad[1]),
    .req_wdata_i(wd[1]), .rsp_valid_o(rv[1]), .rsp_ready_i(rrdy[1]),
    .rsp_rdata_o(rd[1]), .rsp_err_o(er[1]));

  // Drives one full transaction; lat counts cycles from the accept cycle
  // (cycle 0) to the first cycle with rsp_valid_o high.
  task automatic xact(input int s, input logic w, input logic [1:0] z,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err, output int lat);
    int t;
    @(negedge clk);
    vld[s] = 1'b1; we[s] = w; sz[s] = z; ad[s] = a; wd[s] = d;
    t = 0;
    while (!rdy[s] && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    vld[s] = 1'b0;
    lat = 1;
    while (!rv[s] && lat < 40) begin @(posedge clk); #1; lat++; end
    rdata = rd[s]; err = er[s];
    rrdy[s] = 1'b1;
    @(posedge clk); #1;
    rrdy[s] = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid act=%b exp=0", rv[0]); end
    n_chk++; if (er[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err act=%b exp=0", er[0]); end
    n_chk++; if (rd[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata act=%h exp=0", rd[0]); end
    @(negedge clk); rst[0] = 1'b1; rst[1] = 1'b1;
    @(negedge clk);
    n_chk++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready act=%b exp=1", rdy[0]); end
    n_chk++; if (rv[1] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid_u1 act=%b exp=0", rv[1]); end
  endtask

  task automatic test_word_rw();
    logic [31:0] r; logic e; int l;
    xact(0, 1'b1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF, r, e, l);
    n_chk++; if (l !== 2) begin n_fail++; $display("FAIL store_latency act=%0d exp=2", l); end
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL store_err act=%b exp=0", e); end
    xact(0, 1'b0, 2'd2, 32'h8000_0010, 32'h0, r, e, l);
    n_chk++; if (l !== 2) begin n_fail++; $display("FAIL load_latency act=%0d exp=2", l); end
    n_chk++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_word act=%h exp=deadbeef", r); end
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL load_err act=%b exp=0", e); end
  endtask

  task automatic test_byte_half();
    logic [31:0] r; logic e; int l;
    xact(0, 1'b1, 2'd2, 32'h8000_0010, 32'h1122_3344, r, e, l);
    xact(0, 1'b1, 2'd0, 32'h8000_0013, 32'hFFFF_FFA5, r, e, l);
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL store_byte_err act=%b exp=0", e); end
    xact(0, 1'b0, 2'd2, 32'h8000_0010, 32'h0, r, e, l);
    n_chk++; if (r !== 32'hA522_3344) begin n_fail++; $display("FAIL byte_merge act=%h exp=a5223344", r); end
    xact(0, 1'b0, 2'd1, 32'h8000_0012, 32'h0, r, e, l);
    n_chk++; if (r !== 32'h0000_A522) begin n_fail++; $display("FAIL load_half_hi act=%h exp=0000a522", r); end
    xact(0, 1'b0, 2'd0, 32'h8000_0011, 32'h0, r, e, l);
    n_chk++; if (r !== 32'h0000_0033) begin n_fail++; $display("FAIL load_byte1 act=%h exp=00000033", r); end
    xact(0, 1'b0, 2'd0, 32'h8000_0013, 32'h0, r, e, l);
    n_chk++; if (r !== 32'h0000_00A5) begin n_fail++; $display("FAIL load_byte3 act=%h exp=000000a5", r); end
    xact(0, 1'b1, 2'd1, 32'h8000_0010, 32'hABCD_5566, r, e, l);
    xact(0, 1'b0, 2'd2, 32'h8000_0010, 32'h0, r, e, l);
    n_chk++; if (r !== 32'hA522_5566) begin n_fail++; $display("FAIL half_merge act=%h exp=a5225566", r); end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int l;
    xact(0, 1'b1, 2'd2, 32'h8000_0FFC, 32'hCAFE_F00D, r, e, l);
    xact(0, 1'b1, 2'd2, 32'h8000_0000, 32'h0BAD_F00D, r, e, l);
    xact(0, 1'b0, 2'd2, 32'h8000_0002, 32'h0, r, e, l);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL misalign_word_err act=%b exp=1", e); end
    n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL misalign_word_rdata act=%h exp=0", r); end
    xact(0, 1'b1, 2'd2, 32'h7FFF_FFFC, 32'h1111_1111, r, e, l);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL below_base_err act=%b exp=1", e); end
    xact(0, 1'b0, 2'd2, 32'h8000_1000, 32'h0, r, e, l);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL above_top_err act=%b exp=1", e); end
    n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL above_top_rdata act=%h exp=0", r); end
    xact(0, 1'b1, 2'd2, 32'h8000_1000, 32'h2222_2222, r, e, l);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL above_top_store_err act=%b exp=1", e); end
    xact(0, 1'b1, 2'd1, 32'h8000_0FFD, 32'h3333_3333, r, e, l);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL misalign_half_err act=%b exp=1", e); end
    xact(0, 1'b0, 2'd3, 32'h8000_0FFC, 32'h0, r, e, l);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL size3_err act=%b exp=1", e); end
    n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL size3_rdata act=%h exp=0", r); end
    xact(0, 1'b0, 2'd2, 32'h8000_0FFC, 32'h0, r, e, l);
    n_chk++; if (r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL top_word_kept act=%h exp=cafef00d", r); end
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL top_word_err act=%b exp=0", e); end
    xact(0, 1'b0, 2'd2, 32'h8000_0000, 32'h0, r, e, l);
    n_chk++; if (r !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL word0_kept act=%h exp=0badf00d", r); end
  endtask

  task automatic test_stall();
    int t;
    @(negedge clk);
    vld[0] = 1'b1; we[0] = 1'b0; sz[0] = 2'd2; ad[0] = 32'h8000_0010; wd[0] = 32'h0;
    @(posedge clk); #1;
    ad[0] = 32'h8000_0FFC;   // request stays up but must be ignored
    t = 0;
    while (!rv[0] && t < 20) begin @(posedge clk); #1; t++; end
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (rv[0] !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc=%0d act=%b exp=1", i, rv[0]); end
      n_chk++; if (rd[0] !== 32'hA522_5566) begin n_fail++; $display("FAIL stall_rdata cyc=%0d act=%h exp=a5225566", i, rd[0]); end
      n_chk++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc=%0d act=%b exp=0", i, rdy[0]); end
      if (i == 2) vld[0] = 1'b0;
      @(posedge clk); #1;
    end
    rrdy[0] = 1'b1;
    @(posedge clk); #1;
    rrdy[0] = 1'b0;
    n_chk++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL post_hs_ready act=%b exp=1", rdy[0]); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL no_extra_rsp cyc=%0d act=%b exp=0", i, rv[0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] r; logic e; int l;
    xact(1, 1'b1, 2'd2, 32'h8000_0040, 32'h0102_0304, r, e, l);
    n_chk++; if (l !== 4) begin n_fail++; $display("FAIL lat3_latency act=%0d exp=4", l); end
    @(negedge clk);
    vld[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'd2; ad[1] = 32'h8000_0040; wd[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    #1;
    n_chk++; if (rv[1] !== 1'b0) begin n_fail++; $display("FAIL rst_wait_valid act=%b exp=0", rv[1]); end
    #1 rst[1] = 1'b1;
    @(negedge clk);
    n_chk++; if (rdy[1] !== 1'b1) begin n_fail++; $display("FAIL rst_wait_ready act=%b exp=1", rdy[1]); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_chk++; if (rv[1] !== 1'b0) begin n_fail++; $display("FAIL rst_wait_dropped cyc=%0d act=%b exp=0", i, rv[1]); end
    end
    xact(1, 1'b0, 2'd2, 32'h8000_0040, 32'h0, r, e, l);
    n_chk++; if (r !== 32'h0102_0304) begin n_fail++; $display("FAIL rst_wait_no_write act=%h exp=01020304", r); end
    n_chk++; if (l !== 4) begin n_fail++; $display("FAIL lat3_load_latency act=%0d exp=4", l); end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b0; vld[s] = 1'b0; we[s] = 1'b0; sz[s] = 2'd0;
      ad[s] = 32'h0; wd[s] = 32'h0; rrdy[s] = 1'b0;
    end
    test_reset();
    test_word_rw();
    test_byte_half();
    test_errors();
    test_stall();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
